// File: rtl/sma_level_detect_pkg.sv
// Shared definitions for the level detector: state encoding,
// default sample width and threshold helpers.
package sma_level_detect_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  // Sign-extend an integer threshold; callers truncate to DATA_W.
  function automatic logic signed [63:0] thr_sext(input int t);
    return 64'(t);
  endfunction

  function automatic bit params_ok(input int lo, input int hi,
                                   input int hold);
    return (lo <= hi) && (hold >= 1);
  endfunction

endpackage

// File: rtl/sma_level_debounce.sv
// Consecutive-sample hold counter: done fires on the HOLD-th
// qualifying valid sample and the count restarts afterwards.
module sma_level_debounce #(
  parameter int HOLD = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic qualify,
  input  logic restart,
  output logic done
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  assign done = en & qualify & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en & qualify) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sma_level_detect.sv
// Hysteresis level detector with debounce, edge pulses and event counter.
// Optional peak capture of each high episode under SMA_LEVEL_PEAK_EN.
module sma_level_detect
  import sma_level_detect_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int THR_HI = 100,
  parameter int THR_LO = 50,
  parameter int HOLD   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     x_valid,
  input  logic                     cnt_clr,
  output logic                     level,
  output logic                     rise,
  output logic                     fall,
  output logic [CNT_W-1:0]         event_cnt,
  output logic signed [DATA_W-1:0] peak,
  output logic                     peak_vld
);

  localparam logic signed [DATA_W-1:0] THI =
    DATA_W'(thr_sext(THR_HI));
  localparam logic signed [DATA_W-1:0] TLO =
    DATA_W'(thr_sext(THR_LO));

  if (!params_ok(THR_LO, THR_HI, HOLD)) begin : g_param_err
    $error("sma_level_detect: need THR_LO<=THR_HI and HOLD>=1");
  end

  state_t state;
  logic   in_high;
  logic   qualify;
  logic   done;
  logic   rise_c;
  logic   fall_c;

  assign in_high = (state == HIGH) || (state == FALL_PEND);
  assign qualify = in_high ? (x < TLO) : (x > THI);
  assign rise_c  = done & ~in_high;
  assign fall_c  = done & in_high;

  sma_level_debounce #(
    .HOLD (HOLD)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .en      (x_valid),
    .qualify (qualify),
    .restart (x_valid & ~qualify),
    .done    (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= rise_c;
      fall <= fall_c;
      if (rise_c)
        level <= 1'b1;
      else if (fall_c)
        level <= 1'b0;
      if (x_valid) begin
        unique case (state)
          LOW: begin
            if (qualify)
              state <= done ? HIGH : RISE_PEND;
          end
          RISE_PEND: begin
            if (done)
              state <= HIGH;
            else if (!qualify)
              state <= LOW;
          end
          HIGH: begin
            if (qualify)
              state <= done ? LOW : FALL_PEND;
          end
          FALL_PEND: begin
            if (done)
              state <= LOW;
            else if (!qualify)
              state <= HIGH;
          end
        endcase
      end
    end
  end

  // Clear wins over increment, but a same-cycle rise still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt <= '0;
    end else if (cnt_clr) begin
      event_cnt <= rise_c ? CNT_W'(1) : '0;
    end else if (rise_c && (event_cnt != '1)) begin
      event_cnt <= event_cnt + 1'b1;
    end
  end

`ifdef SMA_LEVEL_PEAK_EN
  logic signed [DATA_W-1:0] run_max;
  logic signed [DATA_W-1:0] mx;

  assign mx = (x > run_max) ? x : run_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max  <= '0;
      peak     <= '0;
      peak_vld <= 1'b0;
    end else begin
      peak_vld <= fall_c;
      if (fall_c)
        peak <= mx;
      if (x_valid) begin
        if (state == LOW) begin
          if (qualify)
            run_max <= x;
        end else begin
          run_max <= mx;
        end
      end
    end
  end
`else
  assign peak     = '0;
  assign peak_vld = 1'b0;
`endif

endmodule
